// File: rtl/scan_unit.sv
// scan_unit: receive path for the debug controller.
// Collects one byte or a 4-byte word (MSB first) from the UART RX.
module scan_unit #(
  parameter int TIMEOUT = 1000000,
  parameter int TW      = 20
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_rx,
  input  logic        type_rx,
  input  logic        vld_rx,
  input  logic [7:0]  d_rx,
  output logic        rdy_rx,
  output logic [31:0] din_rx,
  output logic        ack_rx,
  output logic        err_rx
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_t;

  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t        state, state_n;
  logic          req_d;
  logic          start;
  logic          xfer;
  logic [31:0]   shift, shift_n;
  logic [2:0]    cnt, cnt_n;
  logic [TW-1:0] timer, timer_n;
  logic [31:0]   din_n;
  logic          err_n;
  logic          rdy_n;
  logic          ack_n;

  assign start = req_rx & ~req_d;
  assign xfer  = vld_rx & rdy_rx;

  // Next state, datapath updates and registered output values.
  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n   = cnt;
    timer_n = timer;
    din_n   = din_rx;
    err_n   = err_rx;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = RECV;
          cnt_n   = type_rx ? 3'd4 : 3'd1;
          shift_n = '0;
          timer_n = '0;
          err_n   = 1'b0;
        end
      end
      RECV: begin
        if (!req_rx) begin
          state_n = IDLE;
        end else if (xfer) begin
          shift_n = {shift[23:0], d_rx};
          cnt_n   = cnt - 3'd1;
          timer_n = '0;
          if (cnt == 3'd1) begin
            state_n = DONE;
            din_n   = {shift[23:0], d_rx};
            err_n   = 1'b0;
          end
        end else if (TIMEOUT != 0) begin
          if (timer == TLAST) begin
            state_n = DONE;
            din_n   = shift;
            err_n   = 1'b1;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
      end
      DONE: begin
        if (!req_rx) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    rdy_n = (state_n == RECV);
    ack_n = (state_n == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      req_d  <= 1'b0;
      shift  <= '0;
      cnt    <= '0;
      timer  <= '0;
      rdy_rx <= 1'b0;
      ack_rx <= 1'b0;
      err_rx <= 1'b0;
      din_rx <= '0;
    end else begin
      state  <= state_n;
      req_d  <= req_rx;
      shift  <= shift_n;
      cnt    <= cnt_n;
      timer  <= timer_n;
      rdy_rx <= rdy_n;
      ack_rx <= ack_n;
      err_rx <= err_n;
      din_rx <= din_n;
    end
  end

endmodule

// File: doc/scan_unit.md
Name: scan_unit

Overview:
- Receive-side counterpart of the print path. On a request from the debug controller, collects either one raw byte or four raw bytes (MSB first) from the UART receiver over a valid/ready byte handshake.
- Presents the assembled 32-bit result to the controller with a level acknowledge.
- Sits between the UART RX core and the debug command controller.
- Includes an inter-byte timeout so a stalled host cannot hang the controller.

Parameters:
- TIMEOUT, 1000000, idle clock cycles allowed between accepted bytes while receiving; 0 disables the timeout.
- TW, 20, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rstn  input  1  asynchronous, active-low reset
- req_rx  input  1  controller request (level); a rising edge starts a receive
- type_rx  input  1  0 = byte, 1 = word; sampled on the req_rx rising edge
- vld_rx  input  1  UART RX byte valid
- d_rx  input  8  UART RX byte
- rdy_rx  output  1  ready to accept a byte; transfer occurs when vld_rx && rdy_rx at a clock edge
- din_rx  output  32  assembled result, byte right-aligned in byte mode
- ack_rx  output  1  result valid, held until req_rx deasserts
- err_rx  output  1  result ended by timeout; qualified by ack_rx

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; rdy_rx=0, ack_rx=0, err_rx=0, din_rx=0; shift register, byte count, timer and req_d all cleared.
- Edge detect: req_d registers req_rx each cycle; start = req_rx & ~req_d. Because req_d resets to 0, a request already high when reset releases is serviced.

States:
- IDLE:
  - rdy_rx=0, ack_rx=0.
  - On start: latch type_rx; load count = 4 (word) or 1 (byte); clear shift register and timer; go to RECV.
  - err_rx is cleared on start.
- RECV:
  - rdy_rx=1.
  - On transfer: shift = {shift[23:0], d_rx}; count decrements; timer clears.
  - When the transfer consumes the last byte (count==1): next cycle is DONE with rdy_rx=0, din_rx=the new shift value, ack_rx=1, err_rx=0. Latency is 1 cycle from the final transfer edge to ack_rx high.
  - With no transfer and TIMEOUT!=0, the timer increments. When timer==TIMEOUT-1 and no transfer occurs that cycle, go to DONE with din_rx=shift (bytes received so far, right-aligned; zero if none), ack_rx=1, err_rx=1.
  - A transfer in the same cycle as timer expiry wins: the byte is accepted and the timer clears.
  - req_rx low while in RECV aborts: return to IDLE, rdy_rx=0, no ack, din_rx keeps its previous value, err_rx unchanged.
- DONE:
  - ack_rx=1; din_rx and err_rx stable.
  - When req_rx is low, go to IDLE; ack_rx falls on that same edge.
  - vld_rx is ignored; bytes arriving outside RECV are not accepted (rdy_rx=0) and remain the UART's responsibility.

Output and timing rules:
- Byte order: first received byte lands in din_rx[31:24] in word mode, matching the print path's transmit order.
- Byte mode: din_rx = {24'h0, byte}.
- rdy_rx, ack_rx, err_rx and din_rx are all registered outputs; none is driven combinationally from inputs.
- A new request requires req_rx to fall and rise again; a continuously high req_rx yields exactly one transaction.

Test Plan:
- Byte: reset, then req_rx↑ with type_rx=0, then vld_rx pulse with d_rx=8'hA5 → rdy_rx high from the cycle after the edge; 1 cycle after the transfer ack_rx=1, din_rx=32'h000000A5, err_rx=0, rdy_rx=0; ack_rx drops the cycle after req_rx falls.
- Word with gaps (TIMEOUT=16): type_rx=1, bytes 12,34,56,78 separated by 0, 3 and 10 idle cycles → din_rx=32'h12345678, ack_rx=1, err_rx=0; exactly 4 transfers counted.
- Timeout (TIMEOUT=16): word request, bytes DE,AD, then silence → exactly 16 idle cycles after the second transfer, ack_rx=1, err_rx=1, din_rx=32'h0000DEAD; next request clears err_rx. Also check a byte arriving on the expiry cycle is accepted with no timeout.
- Abort and ignored input: word request, 2 bytes, then req_rx↓ → IDLE, no ack, din_rx unchanged. vld_rx pulses while in IDLE or DONE → no transfer (rdy_rx=0), din_rx unchanged.
- Reset mid-operation: rstn low during RECV after 3 bytes → all outputs 0 immediately, without waiting for a clock edge. req_rx held high through reset release → a fresh transaction starts.
- Back-to-back: two byte requests with req_rx low for 1 cycle between them, bytes 01 then 02 → two acks with din_rx 32'h01 then 32'h02; a held-high req_rx produces only one ack.
